mem_access_stage: RTL and testbench
===================================

# mem_access_stage

Data-memory access stage between the EX/MEM and MEM/WB pipeline registers. It decodes load/store width from the instruction opcode and drives a variable-latency req/ack data-memory port with byte enables. It stalls the upstream pipeline while an access is outstanding, then presents the sign/zero-extended load data (or the passed-through ALU result) together with the MEM/WB advance enable.

## Interface
- TIMEOUT_CYCLES, 15: number of REQ-state cycles without memAck before the access is aborted (1..255).
- clk  in  1  pipeline clock; all state updates on posedge.
- reset  in  1  asynchronous, active-high; returns the block to IDLE immediately.
- validInput  in  1  EX/MEM holds a live instruction (0 = bubble).
- memReadFlagInput  in  1  instruction is a load.
- memWriteFlagInput  in  1  instruction is a store.
- IRInput  in  32  instruction; opcode IR[31:26] selects width/extension.
- ResultInput  in  32  ALU result = effective address for loads/stores.
- BInput  in  32  store data (rt value).
- memAck  in  1  memory completion strobe; sampled only in REQ.
- memRdata  in  32  read word; valid when memAck=1 on a read.
- memReq  out  1  registered request.
- memWe  out  1  registered write enable (1 = store).
- memAddr  out  32  registered word address {ResultInput[31:2], 2'b00}.
- memWdata  out  32  registered lane-replicated store data.
- memByteEn  out  4  registered byte-lane enables.
- ResultOutput  out  32  to MEM/WB ResultInput: load data or ALU result.
- stallOutput  out  1  freeze PC, IF/ID, ID/EX, EX/MEM.
- controlSignal  out  1  MEM/WB load enable (= !stallOutput).
- alignError  out  1  registered one-cycle pulse: misaligned access dropped.
- busError  out  1  registered one-cycle pulse: access timed out.

## Operation
- Opcodes: lb 0x20, lh 0x21, lw 0x23, lbu 0x24, lhu 0x25, sb 0x28, sh 0x29, sw 0x2B. Any other opcode with a read/write flag is treated as word.
- access = validInput & (memReadFlagInput | memWriteFlagInput); aligned = word: addr[1:0]==0, half: addr[0]==0, byte: always.
- Little-endian lanes: byte at offset k occupies bits [8k+7:8k].
- Store data: sb replicates BInput[7:0] ×4, byteEn = 1<<addr[1:0]; sh replicates BInput[15:0] ×2, byteEn = 4'b0011 (addr[1]=0) / 4'b1100; sw BInput, 4'b1111. Loads: byteEn = 4'b1111.
- Load extraction from the captured word: lane(s) selected by addr[1:0]; lb/lh sign-extend, lbu/lhu zero-extend.
- FSM states IDLE, REQ, DONE:
  - IDLE: access & aligned -> register memReq=1, memWe, memAddr, memWdata, memByteEn; clear timeout counter; go REQ. access & !aligned -> no request, alignError pulse next cycle, stay IDLE. Otherwise stay IDLE.
  - REQ: memAck=1 -> capture memRdata into loadData, memReq=0, go DONE. memAck=0 -> counter+1; when counter reaches TIMEOUT_CYCLES-1 without ack -> memReq=0, loadData=0, busError pulse, go DONE.
  - DONE: one cycle, unconditionally -> IDLE.
- stallOutput = (IDLE & access & aligned) | REQ; combinational. controlSignal = !stallOutput.
- ResultOutput: DONE & load -> extracted loadData; else ResultInput (stores, misaligned, non-memory ops pass the ALU result).
- Upstream holds all inputs stable while stallOutput=1; inputs are therefore still valid in DONE.
- memAck outside REQ is ignored.

## Timing
- Reset values: state IDLE, memReq 0, memWe 0, memAddr 0, memWdata 0, memByteEn 0, loadData 0, counter 0, alignError 0, busError 0; stallOutput 0, controlSignal 1 (ResultOutput follows ResultInput).
- Non-memory op or bubble: zero added latency, controlSignal=1 same cycle.
- Access with ack in the k-th REQ cycle (k≥1): stall cycles = 1 + k; DONE is cycle k+1 after detection, controlSignal=1 there.
- Request outputs stay constant from REQ entry through the ack cycle; memReq falls the cycle after ack.
- Timeout: stall cycles = 1 + TIMEOUT_CYCLES.
- Reset asserted mid-REQ: memReq drops asynchronously, no DONE cycle, no error pulse.

## Test plan
- Bubble/ALU op, ResultInput=0x1234 -> controlSignal=1, ResultOutput=0x1234, memReq never asserts.
- sw addr 0x100, B=0xDEADBEEF, ack in 1st REQ cycle -> memAddr 0x100, byteEn 1111, wdata 0xDEADBEEF, 2 stall cycles, then advance.
- lb addr 0x203, rdata 0x80FF1234, ack after 3 REQ cycles -> ResultOutput 0xFFFFFF80 in DONE; lbu same -> 0x00000080; lh addr 0x202 -> 0xFFFF80FF.
- sh addr 0x06, B=0x0000ABCD -> byteEn 1100, wdata 0xABCDABCD; lw addr 0x06 -> alignError pulse, no memReq, no stall.
- Read, memAck held 0 -> busError after 15 REQ cycles, ResultOutput 0, 16 stall cycles, back to IDLE.
- Reset raised in 2nd REQ cycle -> memReq and stallOutput 0 immediately; later stray memAck ignored; next lw completes normally.

Source files
------------

// File: rtl/mem_access_stage.sv
`default_nettype none
// mem_access_stage: data-memory access stage with width decode, lane steering,
// load extension, variable-latency req/ack handshake, stall generation and timeout.
module mem_access_stage #(
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        validInput,
  input  logic        memReadFlagInput,
  input  logic        memWriteFlagInput,
  input  logic [31:0] IRInput,
  input  logic [31:0] ResultInput,
  input  logic [31:0] BInput,
  input  logic        memAck,
  input  logic [31:0] memRdata,
  output logic        memReq,
  output logic        memWe,
  output logic [31:0] memAddr,
  output logic [31:0] memWdata,
  output logic [3:0]  memByteEn,
  output logic [31:0] ResultOutput,
  output logic        stallOutput,
  output logic        controlSignal,
  output logic        alignError,
  output logic        busError
);

  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, DONE = 2'd2} state_t;
  localparam logic [7:0] LAST_COUNT = 8'(TIMEOUT_CYCLES - 1);

  state_t      state, state_next;
  logic [7:0]  timeout_count;
  logic [31:0] load_data;
  logic [5:0]  opcode;
  logic [1:0]  offset;
  logic        is_byte, is_half, is_unsigned, access, aligned, is_load, timeout_now;
  logic [31:0] store_data, load_value;
  logic [3:0]  byte_en;
  logic [7:0]  load_byte;
  logic [15:0] load_half;
  logic        unused_ir;

  assign opcode      = IRInput[31:26];
  assign unused_ir   = ^IRInput[25:0];
  assign offset      = ResultInput[1:0];
  assign is_byte     = (opcode == 6'h20) || (opcode == 6'h24) || (opcode == 6'h28);
  assign is_half     = (opcode == 6'h21) || (opcode == 6'h25) || (opcode == 6'h29);
  assign is_unsigned = (opcode == 6'h24) || (opcode == 6'h25);
  assign access      = validInput & (memReadFlagInput | memWriteFlagInput);
  assign is_load     = validInput & memReadFlagInput;
  assign aligned     = is_byte | (is_half ? ~offset[0] : (offset == 2'b00));
  assign timeout_now = (state == REQ) && !memAck && (timeout_count == LAST_COUNT);

  // Sub-word stores replicate the datum across lanes; byte enables pick the lane.
  always_comb begin
    store_data = BInput;
    byte_en    = 4'b1111;
    if (memWriteFlagInput) begin
      if (is_byte) begin
        store_data = {4{BInput[7:0]}};
        byte_en    = 4'b0001 << offset;
      end else if (is_half) begin
        store_data = {2{BInput[15:0]}};
        byte_en    = offset[1] ? 4'b1100 : 4'b0011;
      end
    end
  end

  always_comb begin
    load_byte  = load_data[{offset, 3'b000} +: 8];
    load_half  = offset[1] ? load_data[31:16] : load_data[15:0];
    load_value = load_data;
    if (is_byte)
      load_value = is_unsigned ? {24'b0, load_byte} : {{24{load_byte[7]}}, load_byte};
    else if (is_half)
      load_value = is_unsigned ? {16'b0, load_half} : {{16{load_half[15]}}, load_half};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next    = state;
    stallOutput   = 1'b0;
    case (state)
      IDLE: begin
        if (access && aligned) begin
          state_next  = REQ;
          stallOutput = 1'b1;
        end
      end
      REQ: begin
        stallOutput = 1'b1;
        if (memAck || timeout_now) state_next = DONE;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
    controlSignal = ~stallOutput;
    ResultOutput  = (state == DONE && is_load) ? load_value : ResultInput;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      memReq        <= 1'b0;
      memWe         <= 1'b0;
      memAddr       <= 32'b0;
      memWdata      <= 32'b0;
      memByteEn     <= 4'b0;
      load_data     <= 32'b0;
      timeout_count <= 8'b0;
      alignError    <= 1'b0;
      busError      <= 1'b0;
    end else begin
      alignError <= 1'b0;
      busError   <= 1'b0;
      case (state)
        IDLE: begin
          if (access && aligned) begin
            memReq        <= 1'b1;
            memWe         <= memWriteFlagInput;
            memAddr       <= {ResultInput[31:2], 2'b00};
            memWdata      <= store_data;
            memByteEn     <= byte_en;
            timeout_count <= 8'b0;
          end else if (access) begin
            alignError <= 1'b1;
          end
        end
        REQ: begin
          if (memAck) begin
            load_data <= memRdata;
            memReq    <= 1'b0;
          end else if (timeout_now) begin
            load_data <= 32'b0;
            memReq    <= 1'b0;
            busError  <= 1'b1;
          end else begin
            timeout_count <= timeout_count + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_access_stage.sv
`default_nettype none
// Bench for mem_access_stage: directed vector table, reset-in-REQ sequence and
// randomized transactions checked against a behavioural model.
module tb_mem_access_stage;
  localparam int T = 15;

  logic        clk = 1'b0, reset = 1'b1;
  logic        validInput = 1'b0, memReadFlagInput = 1'b0, memWriteFlagInput = 1'b0;
  logic [31:0] IRInput = 32'b0, ResultInput = 32'h0000A5A5, BInput = 32'b0;
  logic        memAck = 1'b0;
  logic [31:0] memRdata = 32'b0;
  logic        memReq, memWe, stallOutput, controlSignal, alignError, busError;
  logic [31:0] memAddr, memWdata, ResultOutput;
  logic [3:0]  memByteEn;

  mem_access_stage #(.TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .reset(reset), .validInput(validInput),
    .memReadFlagInput(memReadFlagInput), .memWriteFlagInput(memWriteFlagInput),
    .IRInput(IRInput), .ResultInput(ResultInput), .BInput(BInput),
    .memAck(memAck), .memRdata(memRdata), .memReq(memReq), .memWe(memWe),
    .memAddr(memAddr), .memWdata(memWdata), .memByteEn(memByteEn),
    .ResultOutput(ResultOutput), .stallOutput(stallOutput),
    .controlSignal(controlSignal), .alignError(alignError), .busError(busError)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic v, rd, wr;
    logic [5:0] op;
    logic [31:0] addr, b, rdata;
    int ack_k;
    logic [31:0] exp_res, exp_wd;
    logic [3:0] exp_be;
    int exp_stalls;
    logic exp_align, exp_bus;
  } vec_t;

  int errors = 0, checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mkv(input logic v, rd, wr, input logic [5:0] op,
                               input logic [31:0] addr, b, rdata, input int k,
                               input logic [31:0] res, wd, input logic [3:0] be,
                               input int stalls, input logic al, bus);
    vec_t t;
    t.v = v; t.rd = rd; t.wr = wr; t.op = op; t.addr = addr; t.b = b; t.rdata = rdata;
    t.ack_k = k; t.exp_res = res; t.exp_wd = wd; t.exp_be = be;
    t.exp_stalls = stalls; t.exp_align = al; t.exp_bus = bus;
    return t;
  endfunction

  // Reference: size in bytes from opcode, alignment by modulo, lanes by shifting.
  function automatic vec_t model(input vec_t t);
    vec_t r;
    int sz, off;
    logic acc, ok, timed, uns;
    logic [31:0] lane;
    r = t;
    off = int'(t.addr % 4);
    sz = (t.op == 6'h20 || t.op == 6'h24 || t.op == 6'h28) ? 1 :
         (t.op == 6'h21 || t.op == 6'h25 || t.op == 6'h29) ? 2 : 4;
    uns = (t.op == 6'h24 || t.op == 6'h25);
    acc = t.v & (t.rd | t.wr);
    ok = (int'(t.addr % 4) % sz) == 0;
    timed = (t.ack_k < 1 || t.ack_k > T);
    r.exp_wd = t.b; r.exp_be = 4'hF;
    if (t.wr && sz == 1) begin r.exp_wd = {4{t.b[7:0]}}; r.exp_be = 4'(1 << off); end
    if (t.wr && sz == 2) begin r.exp_wd = {2{t.b[15:0]}}; r.exp_be = 4'(3 << off); end
    r.exp_res = t.addr; r.exp_stalls = 0; r.exp_align = acc & ~ok; r.exp_bus = 1'b0;
    if (acc && ok) begin
      r.exp_stalls = 1 + (timed ? T : t.ack_k);
      r.exp_bus = timed;
      if (t.rd) begin
        lane = (timed ? 32'b0 : t.rdata) >> (8 * off);
        if (sz == 1)      r.exp_res = uns ? (lane & 32'hFF)   : 32'($signed(lane[7:0]));
        else if (sz == 2) r.exp_res = uns ? (lane & 32'hFFFF) : 32'($signed(lane[15:0]));
        else              r.exp_res = lane;
      end
    end
    return r;
  endfunction

  task automatic txn(input vec_t t, input string tag);
    int stalls, reqs;
    logic done;
    stalls = 0; reqs = 0; done = 1'b0;
    @(posedge clk); #1;
    validInput = t.v; memReadFlagInput = t.rd; memWriteFlagInput = t.wr;
    IRInput = {t.op, 26'h155AA}; ResultInput = t.addr; BInput = t.b; memAck = 1'b0;
    for (int c = 0; c < 300 && !done; c++) begin
      #4;
      if (memReq) begin
        reqs++;
        if (reqs == 1) begin
          chk({tag, " addr"}, memAddr, {t.addr[31:2], 2'b00});
          chk({tag, " we"}, 32'(memWe), 32'(t.wr));
          chk({tag, " byteEn"}, 32'(memByteEn), 32'(t.exp_be));
          if (t.wr) chk({tag, " wdata"}, memWdata, t.exp_wd);
        end
        if (reqs == t.ack_k) begin
          if (reqs > 1) chk({tag, " addr_hold"}, memAddr, {t.addr[31:2], 2'b00});
          memAck = 1'b1; memRdata = t.rdata;
        end
      end
      if (stallOutput) stalls++;
      else begin
        done = 1'b1;
        chk({tag, " result"}, ResultOutput, t.exp_res);
        chk({tag, " ctrl"}, 32'(controlSignal), 32'd1);
        chk({tag, " stalls"}, stalls, t.exp_stalls);
        chk({tag, " reqs"}, reqs, (t.exp_stalls > 0) ? t.exp_stalls - 1 : 0);
        chk({tag, " busError"}, 32'(busError), 32'(t.exp_bus));
        chk({tag, " memReq_low"}, 32'(memReq), 32'd0);
      end
      @(posedge clk); #1;
      memAck = 1'b0;
    end
    if (!done) chk({tag, " advance_timeout"}, 32'd0, 32'd1);
    chk({tag, " alignError"}, 32'(alignError), 32'(t.exp_align));
    chk({tag, " busError_pulse"}, 32'(busError), 32'd0);
    validInput = 1'b0; memReadFlagInput = 1'b0; memWriteFlagInput = 1'b0;
  endtask

  vec_t tbl[15];
  logic [5:0] ops[9] = '{6'h20, 6'h21, 6'h23, 6'h24, 6'h25, 6'h28, 6'h29, 6'h2B, 6'h00};

  initial begin
    vec_t r;
    int n;
    tbl[0]  = mkv(0,0,0,6'h00,32'h1234,0,0,0,32'h1234,0,4'hF,0,0,0);
    tbl[1]  = mkv(1,0,0,6'h08,32'h1234,0,0,0,32'h1234,0,4'hF,0,0,0);
    tbl[2]  = mkv(1,0,1,6'h2B,32'h100,32'hDEADBEEF,0,1,32'h100,32'hDEADBEEF,4'hF,2,0,0);
    tbl[3]  = mkv(1,1,0,6'h20,32'h203,0,32'h80FF1234,3,32'hFFFFFF80,0,4'hF,4,0,0);
    tbl[4]  = mkv(1,1,0,6'h24,32'h203,0,32'h80FF1234,3,32'h00000080,0,4'hF,4,0,0);
    tbl[5]  = mkv(1,1,0,6'h21,32'h202,0,32'h80FF1234,3,32'hFFFF80FF,0,4'hF,4,0,0);
    tbl[6]  = mkv(1,1,0,6'h25,32'h202,0,32'h80FF1234,2,32'h000080FF,0,4'hF,3,0,0);
    tbl[7]  = mkv(1,0,1,6'h29,32'h6,32'h0000ABCD,0,1,32'h6,32'hABCDABCD,4'hC,2,0,0);
    tbl[8]  = mkv(1,1,0,6'h23,32'h6,0,0,1,32'h6,0,4'hF,0,1,0);
    tbl[9]  = mkv(1,1,0,6'h23,32'h40,0,32'h11111111,0,32'h0,0,4'hF,16,0,1);
    tbl[10] = mkv(1,0,1,6'h28,32'h101,32'h00000055,0,1,32'h101,32'h55555555,4'h2,2,0,0);
    tbl[11] = mkv(1,1,0,6'h23,32'h44,0,32'h12345678,15,32'h12345678,0,4'hF,16,0,0);
    tbl[12] = mkv(1,1,0,6'h21,32'h203,0,0,1,32'h203,0,4'hF,0,1,0);
    tbl[13] = mkv(1,1,0,6'h00,32'h8,0,32'hCAFEF00D,1,32'hCAFEF00D,0,4'hF,2,0,0);
    tbl[14] = mkv(1,0,1,6'h28,32'h103,32'h12345699,0,2,32'h103,32'h99999999,4'h8,3,0,0);

    #12;
    chk("rst memReq", 32'(memReq), 0);
    chk("rst memWe", 32'(memWe), 0);
    chk("rst memAddr", memAddr, 0);
    chk("rst memWdata", memWdata, 0);
    chk("rst memByteEn", 32'(memByteEn), 0);
    chk("rst stall", 32'(stallOutput), 0);
    chk("rst ctrl", 32'(controlSignal), 1);
    chk("rst result", ResultOutput, 32'h0000A5A5);
    chk("rst errors", {30'b0, alignError, busError}, 0);
    @(posedge clk); #1 reset = 1'b0;

    for (int i = 0; i < 15; i++) txn(tbl[i], $sformatf("vec%0d", i));

    // Reset raised during the second REQ cycle of a load.
    @(posedge clk); #1;
    validInput = 1'b1; memReadFlagInput = 1'b1; IRInput = {6'h23, 26'b0}; ResultInput = 32'h80;
    n = 0;
    for (int c = 0; c < 10 && n < 2; c++) begin
      @(posedge clk); #1;
      if (memReq) n++;
    end
    chk("rstreq reached", n, 2);
    #2 reset = 1'b1; validInput = 1'b0; memReadFlagInput = 1'b0;
    #1;
    chk("rstreq memReq", 32'(memReq), 0);
    chk("rstreq stall", 32'(stallOutput), 0);
    chk("rstreq ctrl", 32'(controlSignal), 1);
    @(posedge clk); #1 reset = 1'b0;
    memAck = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("stray memReq", 32'(memReq), 0);
    chk("stray stall", 32'(stallOutput), 0);
    chk("stray errors", {30'b0, alignError, busError}, 0);
    memAck = 1'b0;
    txn(mkv(1,1,0,6'h23,32'h80,0,32'h0BADF00D,2,32'h0BADF00D,0,4'hF,3,0,0), "post_rst lw");

    for (int i = 0; i < 40; i++) begin
      r.v = ($urandom_range(0, 7) != 0);
      r.rd = $urandom_range(0, 1);
      r.wr = r.rd ? 1'b0 : 1'($urandom_range(0, 3) != 0);
      r.op = ops[$urandom_range(0, 8)];
      r.addr = $urandom;
      r.b = $urandom;
      r.rdata = $urandom;
      r.ack_k = $urandom_range(0, 17);
      txn(model(r), $sformatf("rnd%0d", i));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
`default_nettype wire
